// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_AW    = 8;
  localparam int unsigned IMEM_DW    = 8;
  localparam int unsigned IMEM_DEPTH = 256;

  // Payload bytes plus the checksum byte must sum to this value (mod 256).
  localparam logic [7:0] CKSUM_TARGET = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LOAD,
    CHK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_cksum.sv
// 8-bit modular accumulator over the payload bytes. o_match reports whether
// adding the byte currently on i_data would land on the checksum target.
module imem_loader_cksum
  import imem_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_add,
  input  logic [7:0] i_data,
  output logic       o_match
);

  logic [7:0] r_acc;
  logic [7:0] w_sum;

  assign w_sum   = r_acc + i_data;
  assign o_match = (w_sum == CKSUM_TARGET);

  // Accumulate payload bytes; cleared at the start of each image.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= w_sum;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length header, payload bytes and (optionally)
// a checksum byte over a valid/ready stream; holds the core until a
// complete image is in memory.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add the checksum byte,
// the CHK state and the err path.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned AW    = IMEM_AW,
  parameter int unsigned DW    = IMEM_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_addr;
  logic [8:0]    r_remain;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_cpu_hold;
  logic          w_last;
  logic          w_hdr_hs;
  logic          w_load_hs;

  assign w_hdr_hs  = (r_state == HDR)  && s_valid;
  assign w_load_hs = (r_state == LOAD) && s_valid;
  assign w_last    = (r_remain == 9'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic w_cksum_ok;

  imem_loader_cksum u_cksum (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_hdr_hs),
    .i_add   (w_load_hs),
    .i_data  (s_data),
    .o_match (w_cksum_ok)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and stream ready; ready depends on state only.
  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = HDR;
      end
      HDR: begin
        s_ready = 1'b1;
        if (s_valid) w_state_next = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (s_valid && w_last) w_state_next = CHK;
`else
        if (s_valid && w_last) w_state_next = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        s_ready = 1'b1;
        if (s_valid) w_state_next = w_cksum_ok ? DONE : ERR;
      end
`endif
      DONE, ERR: begin
        if (start) w_state_next = HDR;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Address and remaining-byte counters; a zero header means a full memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (w_hdr_hs) begin
      r_addr   <= '0;
      r_remain <= (s_data == 8'd0) ? 9'(DEPTH) : {1'b0, s_data};
    end else if (w_load_hs) begin
      r_addr   <= r_addr + 1'b1;
      r_remain <= r_remain - 9'd1;
    end
  end

  // Registered memory write port: one strobe per accepted payload byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_load_hs;
      if (w_load_hs) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= DW'(s_data);
      end
    end
  end

  // Core hold: released only after a full cycle in DONE, so the final
  // payload write has landed before fetch resumes; re-raised with start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cpu_hold <= 1'b1;
    end else begin
      r_cpu_hold <= !((r_state == DONE) && (w_state_next == DONE));
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_hold  = r_cpu_hold;
  assign done      = (r_state == DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err       = (r_state == ERR);
`else
  assign err       = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that fills the processor's 8-bit instruction memory from a byte stream before execution starts. It is the write side of the instruction memory, whose only other user is the core's fetch path. It accepts a length header, the payload bytes and an optional checksum over a valid/ready stream, writing each payload byte to consecutive addresses from 0. It holds the core (`cpu_hold`) until a complete, verified image is in memory.

## Interface
- `DEPTH`, 256: instruction memory depth; must equal 2^`AW`.
- `AW`, 8: address width; matches the PC width.
- `DW`, 8: instruction width (ra 2 + rb 2 + op 4).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- `s_valid`  in  1  stream byte valid.
- `s_data`  in  8  stream byte.
- `s_ready`  out  1  loader can accept a byte; a handshake is `s_valid && s_ready`.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  AW  write address.
- `mem_wdata`  out  DW  write data.
- `cpu_hold`  out  1  holds the core's PC at 0 while high.
- `done`  out  1  a valid image has been loaded.
- `err`  out  1  the checksum did not match.

## Operation
- States:
  - IDLE: wait for `start`.
  - HDR: take the length byte N. N = 0 means 256 bytes.
  - LOAD: take N payload bytes.
  - CHK: take the checksum byte (present only with the macro).
  - DONE.
  - ERR.
- Transitions:
  - IDLE → HDR on `start`.
  - HDR → LOAD on a handshake.
  - LOAD → CHK on the handshake of the Nth byte, or LOAD → DONE when the macro is absent.
  - CHK → DONE if the 8-bit sum of all payload bytes plus the checksum byte, mod 256, is 0x00; otherwise CHK → ERR.
  - DONE or ERR → HDR on `start`. This clears `done`, clears `err` and reasserts `cpu_hold`.
- `s_ready` = 1 exactly in HDR, LOAD and CHK. There is no backpressure beyond that.
- Payload byte k (k = 0..N-1) is written to address k. The write address counter is AW bits wide. With N = 256 the last address is 0xFF and the counter wraps to 0 unused.
- The remaining-byte counter is 9 bits wide so that N = 0 can be represented as 256.
- `start` in HDR, LOAD or CHK is ignored.
- When `s_valid` is low, nothing advances.
- Reset in any state:
  - state → IDLE, counters → 0, checksum accumulator → 0.
  - Memory contents are left untouched.
- Reset values: `s_ready` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `cpu_hold` 1, `done` 0, `err` 0.

## Timing
- `mem_we`, `mem_addr` and `mem_wdata` are registered. The write appears the cycle after the payload handshake and `mem_we` is high for exactly one cycle per byte.
- Back-to-back handshakes give back-to-back writes, one byte per cycle.
- A state change takes effect on the edge that captures the handshake. `s_ready` is combinational from the state.
- `done` and `err` rise the cycle after the final handshake, which is the edge of entry to DONE or ERR.
- `cpu_hold` falls one cycle after DONE is entered. This guarantees the last payload write is committed before fetch resumes.
- `cpu_hold` stays high in ERR.
- `cpu_hold` rises again the cycle after a `start` accepted in DONE or ERR.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - The CHK state, the 8-bit accumulator and the `err` path exist.
  - The stream format is length, payload, checksum.
- Macro not defined:
  - The format is length then payload.
  - LOAD goes straight to DONE.
  - `err` is tied to 0 and ERR is unreachable.

## Structure
- Package `imem_loader_pkg`:
  - state enum (IDLE, HDR, LOAD, CHK, DONE, ERR).
  - constants `IMEM_AW` = 8, `IMEM_DW` = 8, `IMEM_DEPTH` = 256.
  - the checksum target 8'h00.
- Sub-module `imem_loader_cksum`: 8-bit modular accumulator with clear, add-enable and a match flag. It is instantiated only under the macro.
- Everything else lives in the top: the FSM, the address counter, the remaining-byte counter and the output registers.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles → `cpu_hold` = 1, all other outputs 0, state IDLE. Check that `start` during reset is ignored.
- Good load, macro on: `start`, then bytes 0x03, 0x12, 0x34, 0x56, 0x64 → writes (0, 0x12), (1, 0x34), (2, 0x56) on consecutive cycles; `done` = 1 the cycle after 0x64; `cpu_hold` = 0 one cycle later.
- Bad checksum: same stream with 0x65 as the checksum byte → `err` = 1, `done` = 0, `cpu_hold` stays 1. A following `start` plus a good stream → `err` clears and `done` = 1.
- N = 0: a header of 0x00 followed by 256 bytes with values 0..255 → 256 writes, last at address 0xFF with data 0xFF. Checksum 0x80 (payload sum 0x80) → `done`.
- Gapped valid: `s_valid` toggled 1, 0, 1, 0 during LOAD → exactly one `mem_we` per handshake, contiguous addresses, no extra writes.
- Mid-load reset: reset after 2 payload bytes → IDLE with `cpu_hold` = 1. A new `start` with header 0x01 and byte 0xAA → write (0, 0xAA); check that the stale count is not reused.
